// File: rtl/dot_product_ctrl.sv
// Sequences chunked operand reads into an external PE group, then serially reduces its lanes into dot_out.
// Fixed latency: done at cycle vec_len+3+Para_Deg after start (cycle 1 for vec_len=0); no backpressure, abort returns to IDLE.
module dot_product_ctrl #(
  parameter int Data_Width = 8,
  parameter int Para_Deg   = 4,
  parameter int Addr_Width = 8,
  parameter int Len_Width  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [Addr_Width-1:0]                    base_addr,
  input  logic [Len_Width-1:0]                     vec_len,
  output logic                                     rd_en,
  output logic [Addr_Width-1:0]                    rd_addr,
  output logic                                     pe_load_old_output,
  input  logic [Para_Deg*2*Data_Width-1:0]         pe_result,
  output logic                                     busy,
  output logic                                     done,
  output logic [2*Data_Width+$clog2(Para_Deg)-1:0] dot_out
);

  localparam int PW = 2 * Data_Width;
  localparam int OW = PW + $clog2(Para_Deg);
  localparam int LW = (Para_Deg > 1) ? $clog2(Para_Deg) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CAPTURE, REDUCE, DONE} state_e;

  state_e                       state_q, state_d;
  logic [Addr_Width-1:0]        base_q, base_d;
  logic [Len_Width-1:0]         len_q, len_d;
  logic [Len_Width-1:0]         k_q, k_d;
  logic [LW-1:0]                lane_q, lane_d;
  logic [Para_Deg*PW-1:0]       buf_q, buf_d;
  logic [OW-1:0]                acc_q, acc_d;
  logic [OW-1:0]                dot_q, dot_d;
  logic                         ld_q, ld_d;
  logic [PW-1:0]                lane_val;
  logic [OW-1:0]                acc_sum;

  assign lane_val = buf_q[int'(lane_q)*PW +: PW];
  assign acc_sum  = acc_q + OW'(lane_val);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    k_d     = k_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    acc_d   = acc_q;
    dot_d   = dot_q;
    ld_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (vec_len == '0) begin
            state_d = DONE;
            dot_d   = '0;
          end else begin
            state_d = FETCH;
            base_d  = base_addr;
            len_d   = vec_len;
            k_d     = '0;
          end
        end
      end
      FETCH: begin
        // Registered so it lines up with the memory data arriving next cycle.
        ld_d = (k_q != '0);
        if (k_q == len_q - Len_Width'(1)) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d = k_q + Len_Width'(1);
        end
      end
      DRAIN: state_d = CAPTURE;
      CAPTURE: begin
        // The PE registers keep reloading stale data, so snapshot the result now.
        buf_d   = pe_result;
        acc_d   = '0;
        lane_d  = '0;
        state_d = REDUCE;
      end
      REDUCE: begin
        acc_d = acc_sum;
        if (lane_q == LW'(Para_Deg - 1)) begin
          state_d = DONE;
          dot_d   = acc_sum;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      ld_d    = 1'b0;
      k_d     = '0;
      dot_d   = dot_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      acc_q   <= '0;
      dot_q   <= '0;
      ld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      k_q     <= k_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      acc_q   <= acc_d;
      dot_q   <= dot_d;
      ld_q    <= ld_d;
    end
  end

  assign rd_en              = (state_q == FETCH);
  assign rd_addr            = base_q + Addr_Width'(k_q);
  assign pe_load_old_output = ld_q;
  assign busy               = (state_q == FETCH) || (state_q == DRAIN) ||
                              (state_q == CAPTURE) || (state_q == REDUCE);
  assign done               = (state_q == DONE);
  assign dot_out            = dot_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Bench for dot_product_ctrl with operand memories and a PE group modelled around it.
module tb_dot_product_ctrl;
  localparam int DW = 8;
  localparam int P  = 4;
  localparam int AW = 8;
  localparam int LW = 8;
  localparam int OW = 2*DW + 2;

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [AW-1:0]     base_addr;
  logic [LW-1:0]     vec_len;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              pe_load_old_output;
  logic [P*2*DW-1:0] pe_result = '0;
  logic              busy, done;
  logic [OW-1:0]     dot_out;

  int checks = 0;
  int errors = 0;

  dot_product_ctrl #(.Data_Width(DW), .Para_Deg(P), .Addr_Width(AW), .Len_Width(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .vec_len(vec_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .pe_load_old_output(pe_load_old_output), .pe_result(pe_result),
    .busy(busy), .done(done), .dot_out(dot_out)
  );

  always #5 clk = ~clk;

  // Operand memories (1-cycle read latency) and the PE group (registered multiply-accumulate).
  logic [P*DW-1:0] mem_a [256];
  logic [P*DW-1:0] mem_b [256];
  logic [P*DW-1:0] q_a = '0;
  logic [P*DW-1:0] q_b = '0;

  always @(posedge clk) begin
    if (rd_en) begin
      q_a <= mem_a[rd_addr];
      q_b <= mem_b[rd_addr];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < P; i++)
      pe_result[i*2*DW +: 2*DW] <= (pe_load_old_output ? pe_result[i*2*DW +: 2*DW] : 16'd0)
                                   + 16'(q_a[i*DW +: DW]) * 16'(q_b[i*DW +: DW]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) begin
      case (mode)
        0: begin mem_a[i] = 32'h01010101; mem_b[i] = 32'h01010101; end
        1: begin mem_a[i] = 32'h04030201; mem_b[i] = 32'h08070605; end
        2: begin mem_a[i] = 32'hFFFFFFFF; mem_b[i] = 32'hFFFFFFFF; end
        default: begin mem_a[i] = $urandom; mem_b[i] = $urandom; end
      endcase
    end
  endtask

  // Reference: each lane wraps at 16 bits over the chunks, lanes then summed exactly.
  function automatic int model_dot(input int b, input int len);
    int total = 0;
    for (int i = 0; i < P; i++) begin
      int lane = 0;
      for (int k = 0; k < len; k++) begin
        int addr = (b + k) % 256;
        lane = (lane + int'(mem_a[addr][i*DW +: DW]) * int'(mem_b[addr][i*DW +: DW])) % 65536;
      end
      total += lane;
    end
    return total;
  endfunction

  task automatic run_op(input logic [7:0] b, input logic [7:0] len, input int exp_dot, input int exp_done);
    int done_cyc = -1;
    int ndone = 0, bad_rd = 0, bad_ld = 0, bad_busy = 0;
    logic [OW-1:0] dot_at = '1;
    logic exp_ld, exp_busy;
    start = 1'b1; base_addr = b; vec_len = len;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rd_en !== (c <= int'(len))) bad_rd++;
      else if (rd_en && rd_addr !== 8'(int'(b) + c - 1)) bad_rd++;
      exp_ld = (c >= 3) && (c <= int'(len) + 1);
      if (pe_load_old_output !== exp_ld) bad_ld++;
      exp_busy = (len != 0) && (c <= int'(len) + 2 + P);
      if (busy !== exp_busy) bad_busy++;
      if (done === 1'b1) begin ndone++; done_cyc = c; dot_at = dot_out; end
    end
    check("done_cycle", done_cyc, exp_done);
    check("done_count", ndone, 1);
    check("dot_at_done", dot_at, exp_dot);
    check("rd_sequence", bad_rd, 0);
    check("load_old_sequence", bad_ld, 0);
    check("busy_sequence", bad_busy, 0);
    check("dot_hold", dot_out, exp_dot);
  endtask

  typedef struct {
    logic [7:0] base;
    logic [7:0] len;
    int         mode;
    int         exp_dot;
    int         exp_done;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int rdq[$];
    int doneq[$];
    int nd;
    logic busy9;

    tbl[0] = '{8'h10, 8'd3, 0, 12,     10};
    tbl[1] = '{8'h00, 8'd1, 1, 70,     8};
    tbl[2] = '{8'h20, 8'd0, 0, 0,      1};
    tbl[3] = '{8'hFF, 8'd2, 0, 8,      9};
    tbl[4] = '{8'h40, 8'd1, 2, 260100, 8};

    reset = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; vec_len = '0;
    #12;
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_load_old", pe_load_old_output, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dot", dot_out, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int t = 0; t < 5; t++) begin
      fill(tbl[t].mode);
      run_op(tbl[t].base, tbl[t].len, tbl[t].exp_dot, tbl[t].exp_done);
    end

    // Abort mid-FETCH keeps the previous result and lets a new start in at once.
    fill(0);
    run_op(8'h00, 8'd1, 4, 8);
    nd = 0;
    start = 1'b1; base_addr = 8'h30; vec_len = 8'd5;
    @(posedge clk); #1; start = 1'b0;
    if (done === 1'b1) nd++;
    @(posedge clk); #1; abort = 1'b1;
    if (done === 1'b1) nd++;
    @(posedge clk); #1; abort = 1'b0;
    if (done === 1'b1) nd++;
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_load_old", pe_load_old_output, 0);
    check("abort_no_done", nd, 0);
    check("abort_dot_kept", dot_out, 4);
    run_op(8'h00, 8'd2, 8, 9);

    // start held high through DONE: the next acceptance comes only from IDLE.
    start = 1'b1; base_addr = 8'h00; vec_len = 8'd1; busy9 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rd_en === 1'b1) rdq.push_back(c);
      if (done === 1'b1) doneq.push_back(c);
      if (c == 9) busy9 = busy;
      if (c == 10) start = 1'b0;
    end
    check("held_rd_count", rdq.size(), 2);
    check("held_rd_second", (rdq.size() > 1) ? rdq[1] : -1, 10);
    check("held_done_count", doneq.size(), 2);
    check("held_done_first", (doneq.size() > 0) ? doneq[0] : -1, 8);
    check("held_done_second", (doneq.size() > 1) ? doneq[1] : -1, 17);
    check("held_idle_gap_busy", busy9, 0);

    // Reset asserted during REDUCE clears everything asynchronously, no done.
    run_op(8'h00, 8'd2, 8, 9);
    start = 1'b1; base_addr = 8'h00; vec_len = 8'd1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_rd_addr", rd_addr, 0);
    check("mid_rst_load_old", pe_load_old_output, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_dot", dot_out, 0);
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) reset = 1'b1;
      if (done === 1'b1) nd++;
    end
    check("mid_rst_no_done", nd, 0);
    run_op(8'h10, 8'd3, 12, 10);

    for (int r = 0; r < 25; r++) begin
      logic [7:0] b, len;
      b   = 8'($urandom);
      len = 8'($urandom_range(0, 6));
      fill(3);
      run_op(b, len, model_dot(int'(b), int'(len)), (len == 0) ? 1 : int'(len) + 3 + P);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
